// File: rtl/bus_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_axil_pkg
// Brief    : Shared types and constants for the bus-to-AXI4-Lite bridge
// Revision : 1.0
// ============================================================================
package bus_axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_RESP = 3'd4,
        DRAIN   = 3'd5
    } state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExOkay = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    // A disabled timeout still needs a one-bit counter to keep the RTL legal.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RespSlvErr) || (resp == RespDecErr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_axil_bridge.sv
`default_nettype none
// ============================================================================
// Module   : bus_axil_bridge
// Brief    : Ibex bus device port to AXI4-Lite manager, one transaction in flight
// Revision : 1.0
// ============================================================================
module bus_axil_bridge
    import bus_axil_pkg::*;
#(
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dev_req_i,
    input  logic [AddressWidth-1:0]   dev_addr_i,
    input  logic                      dev_we_i,
    input  logic [DataWidth/8-1:0]    dev_be_i,
    input  logic [DataWidth-1:0]      dev_wdata_i,
    output logic                      dev_rvalid_o,
    output logic [DataWidth-1:0]      dev_rdata_o,
    output logic                      dev_err_o,
    output logic                      m_awvalid_o,
    input  logic                      m_awready_i,
    output logic [AddressWidth-1:0]   m_awaddr_o,
    output logic [2:0]                m_awprot_o,
    output logic                      m_wvalid_o,
    input  logic                      m_wready_i,
    output logic [DataWidth-1:0]      m_wdata_o,
    output logic [DataWidth/8-1:0]    m_wstrb_o,
    input  logic                      m_bvalid_i,
    output logic                      m_bready_o,
    input  logic [1:0]                m_bresp_i,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    output logic [AddressWidth-1:0]   m_araddr_o,
    output logic [2:0]                m_arprot_o,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o,
    input  logic [DataWidth-1:0]      m_rdata_i,
    input  logic [1:0]                m_rresp_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = tmo_cnt_width(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntLast =
        CntWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

    state_e                  state_q, state_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic                    we_q, we_d;
    logic [StrbWidth-1:0]    be_q, be_d;
    logic [DataWidth-1:0]    wdata_q, wdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rvalid_q, rvalid_d;
    logic [DataWidth-1:0]    rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [AddressWidth-1:0] pend_addr_q, pend_addr_d;
    logic                    pend_we_q, pend_we_d;
    logic [StrbWidth-1:0]    pend_be_q, pend_be_d;
    logic [DataWidth-1:0]    pend_wdata_q, pend_wdata_d;
    logic                    timeout_hit;

    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        rvalid_d     = 1'b0;
        rdata_d      = '0;
        err_d        = 1'b0;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_we_d    = pend_we_q;
        pend_be_d    = pend_be_q;
        pend_wdata_d = pend_wdata_q;

        unique case (state_q)
            IDLE: begin
                // A request parked during drain takes priority over the live port.
                if (pend_valid_q || dev_req_i) begin
                    pend_valid_d = 1'b0;
                    addr_d  = pend_valid_q ? pend_addr_q  : dev_addr_i;
                    we_d    = pend_valid_q ? pend_we_q    : dev_we_i;
                    be_d    = pend_valid_q ? pend_be_q    : dev_be_i;
                    wdata_d = pend_valid_q ? pend_wdata_q : dev_wdata_i;
                    if (we_d) begin
                        state_d   = WR_ADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                awvalid_d = awvalid_q && !m_awready_i;
                wvalid_d  = wvalid_q && !m_wready_i;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WR_RESP;
                    cnt_d   = '0;
                end
            end
            RD_ADDR: begin
                if (m_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_RESP;
                    cnt_d     = '0;
                end
            end
            WR_RESP: begin
                if (m_bvalid_i) begin
                    rvalid_d = 1'b1;
                    err_d    = resp_is_err(m_bresp_i);
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_RESP: begin
                if (m_rvalid_i) begin
                    rvalid_d = 1'b1;
                    rdata_d  = m_rdata_i;
                    err_d    = resp_is_err(m_rresp_i);
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // Only the abandoned transaction's own channel can still answer.
                if ((we_q && m_bvalid_i) || (!we_q && m_rvalid_i)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == DRAIN) && dev_req_i && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = dev_addr_i;
            pend_we_d    = dev_we_i;
            pend_be_d    = dev_be_i;
            pend_wdata_d = dev_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_we_q    <= 1'b0;
            pend_be_q    <= '0;
            pend_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_we_q    <= pend_we_d;
            pend_be_q    <= pend_be_d;
            pend_wdata_q <= pend_wdata_d;
        end
    end

    assign dev_rvalid_o = rvalid_q;
    assign dev_rdata_o  = rdata_q;
    assign dev_err_o    = err_q;
    assign m_awvalid_o  = awvalid_q;
    assign m_awaddr_o   = addr_q;
    assign m_awprot_o   = 3'b000;
    assign m_wvalid_o   = wvalid_q;
    assign m_wdata_o    = wdata_q;
    assign m_wstrb_o    = be_q;
    assign m_bready_o   = (state_q == WR_RESP) || (state_q == DRAIN);
    assign m_arvalid_o  = arvalid_q;
    assign m_araddr_o   = addr_q;
    assign m_arprot_o   = 3'b000;
    assign m_rready_o   = (state_q == RD_RESP) || (state_q == DRAIN);

`ifndef SYNTHESIS
    a_req_when_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        dev_req_i |-> ((state_q == IDLE) || (state_q == DRAIN)));
    a_pend_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dev_req_i && (state_q == DRAIN)) |-> !pend_valid_q);
`endif

endmodule
`default_nettype wire
